add_sub_mp_seq: RTL

Multi-precision add/subtract sequencer. It time-shares one external add_sub unit (FULLADDER="ON", WIDTH_2-bit, combinational) to process WORDS x WIDTH_2-bit operands, one word per cycle, starting with the least significant word. It chains carry or borrow between words through the unit's cin/cout. It sits beside the add_sub instance in the slice datapath and owns all of its inputs.

---
 rtl/add_sub_mp_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/add_sub_mp_seq.sv
// Multi-precision add/subtract sequencer: drives one shared add_sub unit one word per
// cycle, LSW first, chaining carry/borrow. Optional ZERO_FLAG_EN adds output result_zero.
module add_sub_mp_seq #(
  parameter int WIDTH_2 = 18,
  parameter int WORDS   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic                     op,
  input  logic [WORDS*WIDTH_2-1:0] a,
  input  logic [WORDS*WIDTH_2-1:0] b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WORDS*WIDTH_2-1:0] result,
  output logic                     result_cout,
  output logic                     busy,
  output logic [WIDTH_2-1:0]       au_in1,
  output logic [WIDTH_2-1:0]       au_in2,
  output logic                     au_opmode,
  output logic                     au_cin,
  input  logic [WIDTH_2-1:0]       au_out,
  input  logic                     au_cout,
`ifdef ZERO_FLAG_EN
  output logic                     result_zero,
`endif
  output logic [1:0]               dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and the producer holds its data while valid && !ready.

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state, state_next;
  logic [WORDS*WIDTH_2-1:0] a_q, b_q;
  logic                     op_q;
  logic [KW-1:0]            k;
  logic                     carry_q;
  logic                     accept;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    au_in1      = '0;
    au_in2      = '0;
    au_opmode   = 1'b0;
    au_cin      = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        au_in1    = a_q[k*WIDTH_2 +: WIDTH_2];
        au_in2    = b_q[k*WIDTH_2 +: WIDTH_2];
        au_opmode = op_q;
        // Word 0 starts fresh; later words take the carry/borrow of the previous word.
        au_cin    = (k == '0) ? 1'b0 : carry_q;
        if (k == K_LAST) state_next = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      k           <= '0;
      carry_q     <= 1'b0;
      result      <= '0;
      result_cout <= 1'b0;
`ifdef ZERO_FLAG_EN
      result_zero <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        op_q    <= op;
        k       <= '0;
        carry_q <= 1'b0;
      end
      if (state == RUN) begin
        result[k*WIDTH_2 +: WIDTH_2] <= au_out;
        carry_q                      <= au_cout;
`ifdef ZERO_FLAG_EN
        result_zero <= (k == '0) ? (au_out == '0) : (result_zero & (au_out == '0));
`endif
        if (k == K_LAST) result_cout <= au_cout;
        else             k           <= k + 1'b1;
      end
    end
  end

endmodule
